// File: rtl/sls_pkg.sv
// Shared definitions for the single load/store memory sequencer.
//   sls_size_e   : access size encodings (also used per RAM beat)
//   sls_state_e  : sequencer FSM states
//   DWORD_STRIDE : byte offset of the second word of a doubleword access
//   is_misaligned: natural-alignment check used when SLS_ALIGN_CHECK_EN is defined
package sls_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } sls_size_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBeat0 = 2'b01,
        StBeat1 = 2'b10,
        StResp  = 2'b11
    } sls_state_e;

    localparam logic [31:0] DWORD_STRIDE = 32'd4;

    // Halfwords need addr[0]==0; words and doublewords need addr[1:0]==0.
    function automatic logic is_misaligned(sls_size_e size, logic [1:0] addr_lo);
        case (size)
            SZ_HALF:          return addr_lo[0];
            SZ_WORD, SZ_DWORD: return |addr_lo;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sls_mem_sequencer_if.sv
// Bus bundle between control unit, sequencer and data RAM.
//   req_*  : access request from the control unit (req_ready back)
//   mem_*  : MFA/MOC handshake and beat fields towards the RAM
//   rsp_*  : one-cycle completion response to the control unit
// Modports: master = the sequencer, slave = control unit + RAM side.
interface sls_mem_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic        req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;

    logic        mem_mfa;
    logic        mem_rw;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_moc;

    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        input  req_valid, req_rw, req_sext, req_size, req_addr, req_wdata,
        output req_ready,
        output mem_mfa, mem_rw, mem_size, mem_addr, mem_wdata,
        input  mem_rdata, mem_moc,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        output req_valid, req_rw, req_sext, req_size, req_addr, req_wdata,
        input  req_ready,
        input  mem_mfa, mem_rw, mem_size, mem_addr, mem_wdata,
        output mem_rdata, mem_moc,
        input  rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/sls_load_extend.sv
// Combinational load-data extension.
//   size_i : access size (byte/halfword extended, word/dword passed raw)
//   sext_i : 1 = sign-extend, 0 = zero-extend
//   data_i : right-justified RAM read data
//   data_o : extended 32-bit result
module sls_load_extend
    import sls_pkg::*;
(
    input  sls_size_e   size_i,
    input  logic        sext_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        unique case (size_i)
            SZ_BYTE:  data_o = {{24{sext_i & data_i[7]}}, data_i[7:0]};
            SZ_HALF:  data_o = {{16{sext_i & data_i[15]}}, data_i[15:0]};
            default:  data_o = data_i;
        endcase
    end

endmodule

// File: rtl/sls_mem_sequencer.sv
// Single load/store memory sequencer: accepts one access from the control
// unit, runs the MFA/MOC handshake with the data RAM (doublewords as two
// word beats), extends load data and returns a one-cycle response.
//   clk, reset : clock, synchronous active-high reset
//   bus        : sls_mem_sequencer_if.master (req_*, mem_*, rsp_*)
// Parameters: MOC_TIMEOUT (cycles per beat before abort), TCNT_W (counter width).
// Optional macro SLS_ALIGN_CHECK_EN: misaligned requests complete with rsp_err
// and never reach the RAM.
module sls_mem_sequencer
    import sls_pkg::*;
#(
    parameter int unsigned MOC_TIMEOUT = 16,
    parameter int unsigned TCNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sls_mem_sequencer_if.master  bus
);

    localparam logic [TCNT_W-1:0] TcntLast = TCNT_W'(MOC_TIMEOUT - 1);

    sls_state_e        state_q, state_d;
    logic              rw_q, rw_d;
    logic              sext_q, sext_d;
    sls_size_e         size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       ext_data;

    sls_load_extend u_load_extend (
        .size_i (size_q),
        .sext_i (sext_q),
        .data_i (bus.mem_rdata),
        .data_o (ext_data)
    );

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        sext_d  = sext_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        tcnt_d  = tcnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        bus.req_ready = 1'b0;
        bus.mem_mfa   = 1'b0;
        bus.mem_rw    = 1'b0;
        bus.mem_size  = 2'b00;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    rw_d    = bus.req_rw;
                    sext_d  = bus.req_sext;
                    size_d  = sls_size_e'(bus.req_size);
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    tcnt_d  = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = StBeat0;
`ifdef SLS_ALIGN_CHECK_EN
                    if (is_misaligned(sls_size_e'(bus.req_size), bus.req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
`endif
                end
            end
            StBeat0: begin
                bus.mem_mfa   = 1'b1;
                bus.mem_rw    = rw_q;
                bus.mem_size  = (size_q == SZ_DWORD) ? SZ_WORD : size_q;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q[31:0];
                // MOC wins over a timeout landing in the same cycle.
                if (bus.mem_moc) begin
                    lo_d = bus.mem_rdata;
                    if (size_q == SZ_DWORD) begin
                        tcnt_d  = '0;
                        state_d = StBeat1;
                    end else begin
                        rdata_d = rw_q ? {32'b0, ext_data} : 64'b0;
                        state_d = StResp;
                    end
                end else if (tcnt_q == TcntLast) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StResp;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            StBeat1: begin
                bus.mem_mfa   = 1'b1;
                bus.mem_rw    = rw_q;
                bus.mem_size  = SZ_WORD;
                bus.mem_addr  = addr_q + DWORD_STRIDE;
                bus.mem_wdata = wdata_q[63:32];
                if (bus.mem_moc) begin
                    rdata_d = rw_q ? {bus.mem_rdata, lo_q} : 64'b0;
                    state_d = StResp;
                end else if (tcnt_q == TcntLast) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = StResp;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            StResp: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rdata_q;
                bus.rsp_err   = err_q;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rw_q    <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            tcnt_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            sext_q  <= sext_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            tcnt_q  <= tcnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/sls_mem_sequencer.md
Name: sls_mem_sequencer

Overview:
- Sequences single load/store accesses on the data RAM port, using the RAM settings produced by the single load/store decode (R/W, sign extension, data size).
- Runs the memory-function-active / memory-operation-complete (MFA/MOC) handshake with the RAM and splits doubleword (LDRD/STRD) accesses into two word beats.
- Sign- or zero-extends byte/halfword loads and returns a response to the control unit.
- Bounds every beat with a MOC timeout.

Parameters:
- MOC_TIMEOUT, 16: maximum cycles per beat with mem_mfa=1 and no mem_moc before the access aborts with error; range 2..255.
- TCNT_W, 8: width of the timeout counter; must hold MOC_TIMEOUT.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  control unit presents an access.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_rw  in  1  1=read (load), 0=write (store).
- req_sext  in  1  1=sign-extend load data (byte/halfword only).
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 doubleword.
- req_addr  in  32  byte address.
- req_wdata  in  64  store data; [31:0] is beat 0, [63:32] is beat 1 (right-justified for byte/halfword).
- mem_mfa  out  1  memory function active.
- mem_rw  out  1  1=read.
- mem_size  out  2  per-beat size; doubleword is issued as 10.
- mem_addr  out  32  beat address.
- mem_wdata  out  32  beat store data.
- mem_rdata  in  32  RAM read data, right-justified; valid when mem_moc=1.
- mem_moc  in  1  memory operation complete.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  64  load result; word in [31:0], doubleword is {beat1,beat0}; 0 for stores or on error.
- rsp_err  out  1  qualifies rsp_valid; 1 means timeout (or misalignment, with the optional feature).

Behaviour:
- Reset (synchronous, active-high) puts the FSM in IDLE and clears the timeout counter.
  - Reset values: req_ready=1, mem_mfa=0, mem_rw=0, mem_size=00, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Reset mid-access drops mem_mfa at that edge and discards the request; no response is issued.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE: req_ready=1. When req_valid=1, capture all req_* fields and go to BEAT0.
  - BEAT0: mem_mfa=1, mem_addr=addr, mem_wdata=wdata[31:0], mem_rw=rw, mem_size=(size==11 ? 10 : size).
    - When mem_moc=1: latch mem_rdata into lo. If size==11, go to BEAT1; otherwise go to RESP.
  - BEAT1: mem_mfa=1, mem_addr=addr+4 (mod 2^32, wraps 0xFFFFFFFC to 0x00000000), mem_wdata=wdata[63:32], mem_size=10.
    - When mem_moc=1: latch mem_rdata into hi and go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, mem_mfa=0, then return to IDLE. No back-to-back accept in the RESP cycle.
- mem_mfa deasserts on the edge after mem_moc is sampled high. Between beats it drops for zero cycles: BEAT1 drives new address/data with mfa held high.
- mem_moc while mem_mfa=0 is ignored.
- Latency: accept at edge N, mem_mfa high from cycle N+1, MOC sampled at edge M, rsp_valid in cycle M+1. Minimum accept-to-response is 2 cycles for single-beat and 3 cycles for doubleword accesses.
- Load extension is computed at RESP entry:
  - byte: {24{sext&d[7]}, d[7:0]}
  - halfword: {16{sext&d[15]}, d[15:0]}
  - word/dword: raw; req_sext ignored.
  - Stores: rsp_rdata=0.
- Timeout: the counter resets on entry to each beat and increments each beat cycle with mem_moc=0.
  - At count==MOC_TIMEOUT-1 with no MOC, go to RESP with rsp_err=1 and rsp_rdata=0; BEAT1 is skipped.
  - MOC arriving in the same cycle as the timeout wins (normal completion).
- req_* inputs are ignored outside IDLE; changes during an access have no effect.

Optional Feature:
- Macro: SLS_ALIGN_CHECK_EN.
- Defined: in IDLE, a misaligned request (halfword with addr[0]!=0; word/dword with addr[1:0]!=0) is accepted but goes directly to RESP. Result: rsp_err=1, rsp_rdata=0, mem_mfa never asserted.
- Undefined: no check; the address is passed to the RAM unmodified.

Decomposition:
- Package sls_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - FSM state encodings;
  - the DWORD_STRIDE=4 constant.
- One sub-module: sls_load_extend, combinational (size, sext, data in; 32-bit result), reused by future load paths.

Test Plan:
- Signed byte load: addr 0x100, size 00, sext=1, RAM returns 0x000000F0 with MOC 2 cycles after mfa -> rsp_rdata=0xFFFFFFF0, rsp_err=0, rsp_valid exactly one cycle.
- Unsigned halfword load: mem_rdata 0x00008001, sext=0 -> rsp_rdata=0x00008001. With sext=1 -> rsp_rdata=0xFFFF8001.
- Doubleword store: addr 0x200, wdata 0x11112222_33334444 -> beat0 at 0x200 with 0x33334444, then beat1 at 0x204 with 0x11112222; mem_size=10 on both beats; single rsp_valid.
- Timeout: MOC_TIMEOUT=16, mem_moc held 0 -> after 16 mfa cycles, rsp_err=1, rsp_rdata=0, mfa low. For a dword, no beat1 is issued.
- Reset mid-access: assert reset in BEAT1 of a dword load -> next cycle mem_mfa=0, req_ready=1, no rsp_valid.
- SLS_ALIGN_CHECK_EN defined, word load at 0x102 -> no mfa, rsp_err=1 two cycles after accept. Undefined -> mem_addr=0x102 on the RAM port.
